uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the next generation of the team's fixed 8N1 transmitter.
- Configurable data width, parity mode and stop-bit count.
- Internal bit-period divider, so no external baud strobe.
- One-entry holding register behind a valid/ready handshake, which allows gapless back-to-back frames.
- Sits between the core's I/O bus adapter and the board TX pin.

Parameters:
CLK_DIV, 16, clk cycles per bit period; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, PARITY_NONE, parity mode; one of PARITY_NONE, PARITY_ODD, PARITY_EVEN (from uart_pkg).
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
clk  input  1  clock.
rst  input  1  reset: synchronous, active-high.
s_data  input  DATA_BITS  byte to send; sampled only on handshake.
s_valid  input  1  s_data is valid.
s_ready  output  1  holding register empty; can accept.
tx  output  1  serial line; idle high; registered.
tx_busy  output  1  high when a frame is in progress or the holding register is full.
tx_done  output  1  one-cycle pulse in the last clk cycle of the final stop bit.

Behaviour:
- Reset, while rst is high at a clk edge:
  - state=IDLE, tx=1, hold empty, bit counter=0, tx_done=0, tx_busy=0.
  - s_ready is forced 0 while rst is high.
  - rst has priority over every other event.
- Reset mid-frame: tx returns to 1 after that edge, the frame is aborted, hold contents are discarded, and no tx_done is issued.
- Handshake:
  - Transfer occurs on a clk edge with s_valid && s_ready; s_data is copied into hold.
  - s_ready = !hold_full (registered flag, no combinational path from s_valid).
- Frame format: start(0), data LSB first, optional parity, STOP_BITS stop(1).
  - Every bit lasts exactly CLK_DIV cycles.
  - Frame length = (1+DATA_BITS+P+STOP_BITS)*CLK_DIV cycles, where P=1 if PARITY != NONE.
- Parity is computed over the latched data:
  - EVEN: XOR-reduce of data (total ones including parity is even).
  - ODD: its inverse.
- State machine: IDLE, START, DATA, PAR, STOP.
  - Bit-period counter counts 0..CLK_DIV-1; the end-of-bit tick is at count CLK_DIV-1.
  - The counter clears on every frame start.
  - IDLE -> START when hold_full. On the same edge hold moves into the shift register, hold_full clears, and tx=0.
  - START -> DATA on tick.
  - DATA: shift on each tick. After DATA_BITS bits go to PAR if PARITY != NONE, else STOP.
  - PAR -> STOP on tick.
  - STOP: counts STOP_BITS ticks. On the final tick, tx_done=1 for that one cycle. Next state is START if hold_full (gapless, tx=0 on the next cycle), else IDLE.
- Latency: handshake at edge E0 -> tx falls after edge E0+1 when the transmitter was idle.
- Simultaneous events:
  - A handshake in the same cycle as the final stop tick is impossible because s_ready=0 whenever hold is full.
  - If hold was empty at that edge, the data is captured and starts from IDLE on the next edge (one idle cycle, tx=1).
- tx_busy = (state != IDLE) || hold_full.
- Illegal parameter values cause an elaboration-time $error.

Decomposition:
- uart_pkg holds:
  - typedef enum parity_t {PARITY_NONE, PARITY_ODD, PARITY_EVEN};
  - typedef enum tx_state_t {IDLE, START, DATA, PAR, STOP};
  - localparam MAX_DATA_BITS=9.
- Sub-module uart_baud_gen #(CLK_DIV): counter with a clear input and a one-cycle tick output at count CLK_DIV-1.
- Everything else stays in uart_tx_frame.

Test Plan:
1. CLK_DIV=4, 8 data bits, no parity, 1 stop bit: send 0xA5.
   -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
   -> tx_done high only in cycle 40.
   -> tx_busy high from the handshake to the frame end.
2. PARITY_EVEN with 0x07 -> parity bit 1. PARITY_ODD with 0x07 -> parity bit 0. Frame length 44 cycles at CLK_DIV=4.
3. Back-to-back: present 0x55 then 0xAA with s_valid held high.
   -> Second handshake occurs while the first frame is active.
   -> Two frames total 80 cycles with no idle cycle between stop and start.
   -> Exactly two tx_done pulses.
4. DATA_BITS=7, STOP_BITS=2, CLK_DIV=3: send 0x7F.
   -> Start bit, seven 1 bits, two stop bits.
   -> 30 cycles total.
   -> Eighth input bit ignored.
5. Assert rst for 1 cycle at cycle 10 of a frame with hold full.
   -> tx=1 on the next cycle, tx_busy=0, s_ready=1 after rst drops, no tx_done, no further frame transmitted.
6. s_valid held low for 100 cycles after reset.
   -> tx stays 1, tx_busy=0, s_ready=1, no tx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Parity modes, FSM states and a parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int MAX_DATA_BITS = 9;
  localparam int MIN_DATA_BITS = 5;

  // Even parity is the XOR of all data bits; odd is its inverse.
  // Unused upper bits must be zero.
  function automatic logic parity_bit(
    input logic [MAX_DATA_BITS-1:0] d,
    input parity_t                  mode
  );
    return (^d) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 and ticks on the last count.
// Clear holds the count at zero so every frame starts on a fresh period.
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick is not gated by clear: the FSM loads the next frame on it.
  assign tick_o = (cnt_q == LAST);

  // Next count: zero on clear or wrap, otherwise increment.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register; clear doubles as reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding register.
// Start, LSB-first data, optional parity, one or two stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int      CLK_DIV   = 16,
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY    = PARITY_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
    $error("uart_tx_frame: CLK_DIV out of range");
  end
  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_bits
    $error("uart_tx_frame: DATA_BITS out of range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam logic       HAS_PAR   = (PARITY != PARITY_NONE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;

  logic tick;
  logic load;
  logic done;
  logic accept;
  logic clear;

  assign s_ready = !hold_full_q && !rst;
  assign accept  = s_valid && s_ready;
  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE) || hold_full_q;
  assign tx_done = done && !rst;
  assign clear   = rst || (state_q == IDLE) || load;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .clear_i(clear),
    .tick_o (tick)
  );

  // Frame sequencer: next state, next line level and frame load.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    load      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (HAS_PAR) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            done      = 1'b1;
            bit_cnt_d = '0;
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      shift_d = hold_q;
      par_d   = parity_bit(MAX_DATA_BITS'(hold_q), PARITY);
    end
  end

  // Holding register: filled on handshake, emptied on frame load.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers with synchronous reset that aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame across four configurations.
// Waveforms are checked cycle by cycle against hand-built bit patterns.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic [8:0] sd [4];
  logic       sv [4];
  logic       tx_w [4];
  logic       rdy_w [4];
  logic       busy_w [4];
  logic       done_w [4];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLK_DIV(4), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)
  ) u_d0 (
    .clk(clk), .rst(rst), .s_data(sd[0][7:0]), .s_valid(sv[0]),
    .s_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]),
    .tx_done(done_w[0])
  );

  uart_tx_frame #(
    .CLK_DIV(4), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)
  ) u_d1 (
    .clk(clk), .rst(rst), .s_data(sd[1][7:0]), .s_valid(sv[1]),
    .s_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
    .tx_done(done_w[1])
  );

  uart_tx_frame #(
    .CLK_DIV(4), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1)
  ) u_d2 (
    .clk(clk), .rst(rst), .s_data(sd[2][7:0]), .s_valid(sv[2]),
    .s_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]),
    .tx_done(done_w[2])
  );

  uart_tx_frame #(
    .CLK_DIV(3), .DATA_BITS(7), .PARITY(PARITY_NONE), .STOP_BITS(2)
  ) u_d3 (
    .clk(clk), .rst(rst), .s_data(sd[3][6:0]), .s_valid(sv[3]),
    .s_ready(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]),
    .tx_done(done_w[3])
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_tx k%0d", tag, k), tx_w[k], 1'b1);
      chk($sformatf("%s_busy k%0d", tag, k), busy_w[k], 1'b0);
      chk($sformatf("%s_rdy k%0d", tag, k), rdy_w[k], 1'b1);
      chk($sformatf("%s_done k%0d", tag, k), done_w[k], 1'b0);
      step();
    end
  endtask

  // Handshake, then one idle cycle before the start bit appears.
  task automatic send(input int k, input logic [8:0] d,
                      input bit keep, input logic [8:0] d2);
    sd[k] = d;
    sv[k] = 1'b1;
    chk($sformatf("hs_rdy k%0d", k), rdy_w[k], 1'b1);
    step();
    if (keep) sd[k] = d2;
    else sv[k] = 1'b0;
    chk($sformatf("lat_tx k%0d", k), tx_w[k], 1'b1);
    chk($sformatf("lat_busy k%0d", k), busy_w[k], 1'b1);
    chk($sformatf("lat_rdy k%0d", k), rdy_w[k], 1'b0);
    step();
  endtask

  // Walk the frame; pat MSB is the first bit on the line.
  task automatic frame(input int k, input logic [31:0] pat,
                       input int nbits, input int div, input int flen,
                       input bit b2b, input int stop_at);
    int ndone;
    int total;
    ndone = 0;
    total = nbits * div;
    for (int c = 0; c < total; c++) begin
      if (c == stop_at) break;
      if (b2b && c == 1) begin
        chk($sformatf("b2b_accept k%0d", k), rdy_w[k], 1'b0);
        sv[k] = 1'b0;
      end
      chk($sformatf("tx k%0d c%0d", k, c), tx_w[k],
          pat[nbits - 1 - c / div]);
      chk($sformatf("done k%0d c%0d", k, c), done_w[k],
          ((c + 1) % flen) == 0);
      chk($sformatf("busy k%0d c%0d", k, c), busy_w[k], 1'b1);
      if (done_w[k]) ndone++;
      step();
    end
    if (stop_at >= total) begin
      chk_n($sformatf("ndone k%0d", k), ndone, total / flen);
      chk($sformatf("end_tx k%0d", k), tx_w[k], 1'b1);
      chk($sformatf("end_busy k%0d", k), busy_w[k], 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sd[k] = '0;
      sv[k] = 1'b0;
    end
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_rdy k%0d", k), rdy_w[k], 1'b0);
      chk($sformatf("rst_tx k%0d", k), tx_w[k], 1'b1);
      chk($sformatf("rst_busy k%0d", k), busy_w[k], 1'b0);
      chk($sformatf("rst_done k%0d", k), done_w[k], 1'b0);
    end
    rst = 1'b0;
    step();

    idle(0, 100, "quiet");

    send(0, 9'h0A5, 1'b0, 9'h000);
    frame(0, 32'b0101001011, 10, 4, 40, 1'b0, 1000);
    idle(0, 3, "t1");

    send(1, 9'h007, 1'b0, 9'h000);
    frame(1, 32'b01110000011, 11, 4, 44, 1'b0, 1000);
    send(2, 9'h007, 1'b0, 9'h000);
    frame(2, 32'b01110000001, 11, 4, 44, 1'b0, 1000);

    send(0, 9'h055, 1'b1, 9'h0AA);
    frame(0, 32'b01010101010010101011, 20, 4, 40, 1'b1, 1000);
    idle(0, 3, "t3");

    send(3, 9'h0FF, 1'b0, 9'h000);
    frame(3, 32'b0111111111, 10, 3, 30, 1'b0, 1000);
    idle(3, 3, "t4");

    send(0, 9'h055, 1'b1, 9'h0AA);
    frame(0, 32'b01010101010010101011, 20, 4, 40, 1'b1, 10);
    chk("mid_busy", busy_w[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", rdy_w[0], 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_tx", tx_w[0], 1'b1);
    chk("post_rst_busy", busy_w[0], 1'b0);
    chk("post_rst_rdy", rdy_w[0], 1'b1);
    chk("post_rst_done", done_w[0], 1'b0);
    step();
    idle(0, 60, "abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
